// File: rtl/keypad_entry_if.sv
// Keypad entry bus: raw key lines in, entry register and status pulses out.
interface keypad_entry_if #(
    parameter int DIGITS = 4
) ();
    logic [9:0]                     keypad_buttons;
    logic                           backspace_btn;
    logic [4*DIGITS-1:0]            keypad_values;
    logic                           shift_pulse;
    logic [$clog2(DIGITS+1)-1:0]    digit_count;
    logic                           key_error;

    modport master (
        output keypad_buttons,
        output backspace_btn,
        input  keypad_values,
        input  shift_pulse,
        input  digit_count,
        input  key_error
    );

    modport slave (
        input  keypad_buttons,
        input  backspace_btn,
        output keypad_values,
        output shift_pulse,
        output digit_count,
        output key_error
    );
endinterface

// File: rtl/keypad_entry.sv
// Debounced 10-key keypad feeding a nibble shift register of entered digits.
// Optional backspace support is enabled by defining KEYPAD_BACKSPACE_EN.
module keypad_entry #(
    parameter int         DIGITS          = 4,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [3:0] BLANK_CODE      = 4'hA
) (
    input  logic          clk,
    input  logic          reset_shift,
    keypad_entry_if.slave bus
);
    localparam int CNTW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DCW  = $clog2(DIGITS + 1);
    localparam logic [CNTW-1:0] DB_LOAD = CNTW'(DEBOUNCE_CYCLES);
    localparam logic [CNTW-1:0] DB_LAST = CNTW'(1);
    localparam logic [DCW-1:0]  DC_MAX  = DCW'(DIGITS);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t              r_state, w_state_next;
    logic [9:0]          r_key_meta, r_key_sync;
    logic [1:0]          r_sync_vld;
    logic                r_armed;
    logic [CNTW-1:0]     r_cnt, w_cnt_next;
    logic [3:0]          r_code, w_code_next;
    logic                r_abort, w_abort_next;
    logic [4*DIGITS-1:0] r_vals, w_vals_next, w_vals_shl;
    logic [DCW-1:0]      r_dcnt, w_dcnt_next;
    logic                r_shift, w_shift_next;
    logic                r_err, w_err_next;
    logic [9:0]          w_latched;
    logic                w_onehot, w_zero, w_foreign;
    logic [3:0]          w_key_code;

    assign w_onehot  = $onehot(r_key_sync);
    assign w_zero    = (r_key_sync == 10'd0);
    assign w_latched = 10'b1 << r_code;
    assign w_foreign = |(r_key_sync & ~w_latched);

    always_comb begin
        w_key_code = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (r_key_sync[k]) w_key_code = 4'(k);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_shl
            if (gi == 0) begin : g_lsb
                assign w_vals_shl[3:0] = r_code;
            end else begin : g_up
                assign w_vals_shl[4*gi +: 4] = r_vals[4*(gi-1) +: 4];
            end
        end
    endgenerate

`ifdef KEYPAD_BACKSPACE_EN
    logic                r_bs_meta, r_bs_sync, r_bs_prev;
    logic                w_bs_edge;
    logic [4*DIGITS-1:0] w_vals_shr;

    // r_bs_prev holds high until the synchronizer carries real data, so a
    // button held through reset does not register as a fresh press.
    always_ff @(posedge clk or posedge reset_shift) begin
        if (reset_shift) begin
            r_bs_meta <= 1'b0;
            r_bs_sync <= 1'b0;
            r_bs_prev <= 1'b1;
        end else begin
            r_bs_meta <= bus.backspace_btn;
            r_bs_sync <= r_bs_meta;
            r_bs_prev <= r_sync_vld[1] ? r_bs_sync : 1'b1;
        end
    end

    assign w_bs_edge = r_bs_sync & ~r_bs_prev;

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_shr
            if (gi == DIGITS - 1) begin : g_msb
                assign w_vals_shr[4*gi +: 4] = BLANK_CODE;
            end else begin : g_down
                assign w_vals_shr[4*gi +: 4] = r_vals[4*(gi+1) +: 4];
            end
        end
    endgenerate
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_code_next  = r_code;
        w_abort_next = r_abort;
        w_vals_next  = r_vals;
        w_dcnt_next  = r_dcnt;
        w_shift_next = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE: begin
`ifdef KEYPAD_BACKSPACE_EN
                if (w_bs_edge && (r_dcnt != '0)) begin
                    w_vals_next  = w_vals_shr;
                    w_dcnt_next  = r_dcnt - DCW'(1);
                    w_shift_next = 1'b1;
                end else
`endif
                if (r_armed && w_onehot) begin
                    w_cnt_next   = DB_LOAD;
                    w_code_next  = w_key_code;
                    w_abort_next = 1'b0;
                    w_state_next = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (r_key_sync != w_latched) begin
                    w_state_next = IDLE;
                end else if (r_cnt == DB_LAST) begin
                    w_state_next = HELD;
                end else begin
                    w_cnt_next = r_cnt - DB_LAST;
                end
            end
            HELD: begin
                if (w_zero) begin
                    w_cnt_next   = DB_LOAD;
                    w_state_next = RELEASE_DB;
                end else if (w_foreign) begin
                    w_abort_next = 1'b1;
                end
            end
            RELEASE_DB: begin
                if (!w_zero) begin
                    w_state_next = HELD;
                end else if (r_cnt == DB_LAST) begin
                    w_state_next = IDLE;
                    if (r_abort) begin
                        w_err_next   = 1'b1;
                        w_abort_next = 1'b0;
                    end else begin
                        w_vals_next  = w_vals_shl;
                        w_shift_next = 1'b1;
                        if (r_dcnt != DC_MAX) w_dcnt_next = r_dcnt + DCW'(1);
                    end
                end else begin
                    w_cnt_next = r_cnt - DB_LAST;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // r_armed stays low after reset until the synchronized keys read all-zero,
    // so a key held across reset is never taken as a press.
    always_ff @(posedge clk or posedge reset_shift) begin
        if (reset_shift) begin
            r_key_meta <= 10'd0;
            r_key_sync <= 10'd0;
            r_sync_vld <= 2'b00;
            r_armed    <= 1'b0;
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_code     <= 4'd0;
            r_abort    <= 1'b0;
            r_vals     <= {DIGITS{BLANK_CODE}};
            r_dcnt     <= '0;
            r_shift    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_key_meta <= bus.keypad_buttons;
            r_key_sync <= r_key_meta;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_armed    <= r_armed | (r_sync_vld[1] & w_zero);
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_code     <= w_code_next;
            r_abort    <= w_abort_next;
            r_vals     <= w_vals_next;
            r_dcnt     <= w_dcnt_next;
            r_shift    <= w_shift_next;
            r_err      <= w_err_next;
        end
    end

    assign bus.keypad_values = r_vals;
    assign bus.shift_pulse   = r_shift;
    assign bus.digit_count   = r_dcnt;
    assign bus.key_error     = r_err;
endmodule
